// File: rtl/spi_master_gen_if.sv
// spi_master_gen_if: CPU-side load/unload strobe handshake bundle for spi_master_gen
interface spi_master_gen_if #(
  parameter int DW   = 8,
  parameter int NSS  = 2,
  parameter int DIVW = 4
);
  logic            load_i;
  logic            unload_i;
  logic [DW-1:0]   datain_i;
  logic [DW-1:0]   dataout_o;
  logic [NSS-1:0]  ss_sel_i;
  logic [DIVW-1:0] div_i;
  logic            cpol_i;
  logic            cpha_i;
  logic            busy_o;
  logic            done_o;
  modport master (
    output load_i, unload_i, datain_i, ss_sel_i, div_i, cpol_i, cpha_i,
    input  dataout_o, busy_o, done_o
  );
  modport slave (
    input  load_i, unload_i, datain_i, ss_sel_i, div_i, cpol_i, cpha_i,
    output dataout_o, busy_o, done_o
  );
endinterface

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI master with per-transfer CPOL/CPHA/divider; SPI_MASTER_LOOPBACK_EN adds mosi->rx loopback when ss_sel==0
module spi_master_gen #(
  parameter int DW   = 8,
  parameter int NSS  = 2,
  parameter int DIVW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_master_gen_if.slave bus,
  output logic           sclk_o,
  output logic           mosi_o,
  input  logic           miso_i,
  output logic [NSS-1:0] ssn_o
);
  localparam int HW = $clog2(2 * DW);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic [NSS-1:0]  ss_q, ss_d;
  logic            sclk_q, sclk_d, mosi_q, mosi_d, cpha_q, cpha_d, done_q, done_d;
  logic            tick, edge_now, lead, shift, sample, rx_bit;
  assign tick     = cnt_q == '0;
  assign edge_now = tick && state_q == XFER;
  assign lead     = ~hcnt_q[0];
  assign shift    = edge_now && (cpha_q ? lead : ~lead);
  assign sample   = edge_now && (cpha_q ? ~lead : lead);
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = (ss_q == '0) ? mosi_q : miso_i;
`else
  assign rx_bit = miso_i;
`endif
  assign sclk_o        = sclk_q;
  assign mosi_o        = mosi_q;
  assign ssn_o         = (state_q == IDLE) ? '1 : ~ss_q;
  assign bus.busy_o    = state_q != IDLE;
  assign bus.done_o    = done_q;
  assign bus.dataout_o = dout_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? cnt_q : tick ? div_q : cnt_q - 1'b1;
    div_d   = div_q;
    cpha_d  = cpha_q;
    ss_d    = ss_q;
    hcnt_d  = edge_now ? hcnt_q + 1'b1 : hcnt_q;
    sclk_d  = edge_now ? ~sclk_q : sclk_q;
    mosi_d  = shift ? tx_q[DW-1] : mosi_q;
    tx_d    = shift ? tx_q << 1 : tx_q;
    rx_d    = sample ? {rx_q[DW-2:0], rx_bit} : rx_q;
    dout_d  = dout_q;
    done_d  = done_q & ~bus.unload_i;
    case (state_q)
      IDLE: if (bus.load_i) begin
        state_d = SETUP;
        cnt_d   = bus.div_i;
        div_d   = bus.div_i;
        cpha_d  = bus.cpha_i;
        ss_d    = bus.ss_sel_i;
        hcnt_d  = '0;
        sclk_d  = bus.cpol_i;
        done_d  = 1'b0;
        mosi_d  = bus.cpha_i ? mosi_q : bus.datain_i[DW-1];
        tx_d    = bus.cpha_i ? bus.datain_i : {bus.datain_i[DW-2:0], 1'b0};
      end
      SETUP: state_d = tick ? XFER : SETUP;
      XFER:  state_d = (edge_now && hcnt_q == HW'(2 * DW - 1)) ? HOLD : XFER;
      HOLD: if (tick) begin
        state_d = IDLE;
        dout_d  = rx_q;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cpha_q  <= 1'b0;
      ss_q    <= '0;
      hcnt_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpha_q  <= cpha_d;
      ss_q    <= ss_d;
      hcnt_q  <= hcnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised successor to the fixed 8-bit, mode-0, single-slave SPI engine in the SoC.
- Word width, slave-select count and SCLK divider width are generics.
- CPOL/CPHA and the SCLK rate are selectable per transfer.
- CPU side keeps the same load/unload strobe handshake, so the SoC decode logic drives it unchanged.

Parameters:
DW, 8, shift word width in bits (>=2)
NSS, 2, number of active-low slave-select outputs (>=1)
DIVW, 4, width of the SCLK half-period divider input

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  1-cycle start strobe; samples datain, div, cpol, cpha, ss_sel
unload  input  1  1-cycle read strobe; clears done
datain  input  DW  word to transmit, MSB first
dataout  output  DW  last received word
ss_sel  input  NSS  one-hot/multi-hot slave mask, bit i=1 asserts ssn[i]
div  input  DIVW  SCLK half-period = div+1 clk cycles
cpol  input  1  SCLK idle level
cpha  input  1  0: sample leading edge; 1: sample trailing edge
busy  output  1  transfer in progress
done  output  1  received word valid, sticky
sclk  output  1  serial clock
mosi  output  1  serial data out
miso  input  1  serial data in
ssn  output  NSS  active-low slave selects

Behaviour:
- Reset, asynchronous on rst_n low:
  - sclk=0, mosi=0, ssn=all 1, dataout=0, busy=0, done=0, FSM=IDLE.
  - Takes effect immediately, including mid-transfer. No partial word reaches dataout.
- FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE. A half-period counter reloads with div at each phase/half-bit boundary.
- IDLE:
  - sclk=latched cpol (0 after reset), ssn all 1.
  - load=1 captures all start inputs into registers, sets busy=1 next cycle, clears done, and goes to SETUP.
- SETUP, div+1 cycles:
  - ssn = ~ss_sel_latched, sclk = cpol.
  - cpha=0: mosi = datain[DW-1] during SETUP.
- XFER, 2*DW half-periods of div+1 cycles each; sclk toggles at each half-period end.
  - cpha=0: sample miso on odd (leading) edges, shift mosi on even (trailing) edges.
  - cpha=1: shift mosi on leading edges, sample on trailing edges. mosi updates first at the first leading edge.
  - Exactly DW samples are taken, MSB first.
- HOLD, div+1 cycles:
  - sclk = cpol, ssn still asserted.
  - On exit: ssn all 1, dataout <= received word, done=1, busy=0, back to IDLE.
- Latency:
  - done rises (2*DW+2)*(div+1) clk cycles after the edge that sampled load.
  - Example: DW=8, div=0 gives 18.
- Changes on div, cpol, cpha, ss_sel or datain while busy=1 are ignored (latched copies are used).
- load while busy=1 is ignored; the current transfer is unaffected.
- unload clears done next cycle. dataout holds its value until the next transfer completes.
- load and unload in the same IDLE cycle: transfer starts and done=0.
- ss_sel=0: transfer runs normally with all ssn high (dummy clocks).
- div=all ones: half-period = 2^DIVW cycles. The counter never wraps into a shorter period.

Optional Feature:
Macro SPI_MASTER_LOOPBACK_EN.
- Defined: when the latched ss_sel==0, the receive path samples internal mosi instead of miso, so dataout==datain after done. Any nonzero ss_sel uses miso.
- Not defined: the receive path always samples miso. No loopback logic is present.

Test Plan:
- DW=8, div=0, cpol=0, cpha=0, ss_sel=01, datain=A5, slave model returns 3C -> mosi bits 1,0,1,0,0,1,0,1; ssn=10 during transfer; done at cycle 18; dataout=3C.
- Mode 3 (cpol=1, cpha=1), div=2, datain=C3, slave returns 5A -> sclk idles high; 8 sclk periods of 6 cycles; done at cycle 54; dataout=5A; ssn back to 11.
- load with datain=FF at cycle 5 of an active A5 transfer -> ignored; mosi stream and dataout match the original A5 transfer; busy stays 1 until cycle 18.
- rst_n low at cycle 9 of a transfer -> same cycle: sclk=0, ssn=11, busy=0, done=0, dataout=0; a new load after release completes normally.
- Completion then unload -> done 1->0 next cycle, dataout unchanged; a load+unload pair in IDLE starts a transfer with done=0.
- Macro defined, ss_sel=00, datain=96, miso tied 0 -> dataout=96. Macro undefined, same stimulus -> dataout=00.
